drum_access_sched: RTL and testbench

DRUM_ACCESS_SCHED -- requirements
Module: drum_access_sched

---
 rtl/drum_access_sched_if.sv | 28 ++
 rtl/drum_access_sched.sv | 136 +++++++++++++
 tb/tb_drum_access_sched.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/drum_access_sched_if.sv
// Request/grant and drum-timing bundle between the drum access scheduler and its two requesters.
interface drum_access_sched_if;
    logic       req_cpu;
    logic [6:0] addr_cpu;
    logic       dbl_cpu;
    logic       req_io;
    logic [6:0] addr_io;
    logic [4:0] bit_time;
    logic [6:0] word_time;
    logic       T0;
    logic       T28;
    logic       gnt_cpu;
    logic       gnt_io;
    logic       xfer;
    logic       xfer_w1;
    logic       done;
    logic       err;

    modport master (
        output req_cpu, addr_cpu, dbl_cpu, req_io, addr_io,
        input  bit_time, word_time, T0, T28, gnt_cpu, gnt_io, xfer, xfer_w1, done, err
    );

    modport slave (
        input  req_cpu, addr_cpu, dbl_cpu, req_io, addr_io,
        output bit_time, word_time, T0, T28, gnt_cpu, gnt_io, xfer, xfer_w1, done, err
    );
endinterface

// File: rtl/drum_access_sched.sv
// Drum timing counters plus single-owner CPU/IO arbitration of the drum transfer window.
// Define DRUM_ACCESS_DOUBLE_EN to honour CPU double-word (two-word, 58-cycle) transfers.
module drum_access_sched (
    input logic                CLOCK,
    input logic                rst,
    drum_access_sched_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StXfer} state_e;

    state_e     state_q, state_d;
    logic [4:0] bit_q;
    logic [6:0] word_q;
    logic       owner_q, owner_d;  // 1: CPU owns the operation, 0: I/O
    logic [6:0] target_q, target_d;
    logic       dbl_q, dbl_d;
    logic [5:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       bit_last;
    logic       win_cpu;
    logic       win_dbl;
    logic [6:0] win_addr;
    logic [6:0] acc_target;
    logic [5:0] last_cnt;

    // Word whose last bit precedes the first bit of word w.
    function automatic logic [6:0] prev_word(input logic [6:0] w);
        return (w == 7'd0) ? 7'd107 : w - 7'd1;
    endfunction

    assign bit_last = (bit_q == 5'd28);

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            bit_q  <= 5'd0;
            word_q <= 7'd0;
        end else begin
            bit_q <= bit_last ? 5'd0 : bit_q + 5'd1;
            if (bit_last) begin
                word_q <= (word_q == 7'd107) ? 7'd0 : word_q + 7'd1;
            end
        end
    end

    always_comb begin
        win_cpu  = bus.req_cpu;
        win_addr = win_cpu ? bus.addr_cpu : bus.addr_io;
`ifdef DRUM_ACCESS_DOUBLE_EN
        win_dbl  = win_cpu & bus.dbl_cpu;
`else
        win_dbl  = 1'b0;
`endif
        acc_target = win_dbl ? {win_addr[6:1], 1'b0} : win_addr;
        last_cnt   = dbl_q ? 6'd57 : 6'd28;

        state_d  = state_q;
        owner_d  = owner_q;
        target_d = target_q;
        dbl_d    = dbl_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_cpu || bus.req_io) begin
                    if (acc_target > 7'd107) begin
                        err_d = 1'b1;
                    end else begin
                        owner_d  = win_cpu;
                        target_d = acc_target;
                        dbl_d    = win_dbl;
                        cnt_d    = 6'd0;
                        state_d  = (bit_last && word_q == prev_word(acc_target)) ? StXfer : StWait;
                    end
                end
            end
            StWait: begin
                // A withdrawn request abandons the wait even on the start cycle.
                if (!(owner_q ? bus.req_cpu : bus.req_io)) begin
                    state_d = StIdle;
                end else if (bit_last && word_q == prev_word(target_q)) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (cnt_q == last_cnt) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            target_q <= 7'd0;
            dbl_q    <= 1'b0;
            cnt_q    <= 6'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            target_q <= target_d;
            dbl_q    <= dbl_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.bit_time  = bit_q;
    assign bus.word_time = word_q;
    assign bus.T0        = (bit_q == 5'd0);
    assign bus.T28       = bit_last;
    assign bus.gnt_cpu   = (state_q != StIdle) & owner_q;
    assign bus.gnt_io    = (state_q != StIdle) & ~owner_q;
    assign bus.xfer      = (state_q == StXfer);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

`ifdef DRUM_ACCESS_DOUBLE_EN
    assign bus.xfer_w1 = (state_q == StXfer) & (cnt_q >= 6'd29);
`else
    logic unused_dbl;
    assign unused_dbl  = bus.dbl_cpu;
    assign bus.xfer_w1 = 1'b0;
`endif
endmodule

// File: tb/tb_drum_access_sched.sv
// Randomized bench for drum_access_sched against an absolute-time window model.
module tb_drum_access_sched;
    localparam longint Rev = 3132;
`ifdef DRUM_ACCESS_DOUBLE_EN
    localparam bit DblEn = 1'b1;
`else
    localparam bit DblEn = 1'b0;
`endif

    logic CLOCK = 1'b0;
    logic rst   = 1'b0;

    drum_access_sched_if bus ();

    drum_access_sched dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: cycles since the last reset edge; drum position is cyc mod Rev.
    longint cyc = 0;
    bit     op_valid = 1'b0;
    bit     op_cpu = 1'b0;
    longint op_acc = 0, op_start = 0, op_end = 0;
    longint done_at = -1, err_at = -1;
    bit     chk_en = 1'b0;

    // Smallest cycle after 'after' at which word 'target' bit 0 passes the head.
    function automatic longint first_at(input longint after, input int target);
        longint base = after + 1;
        longint off  = (longint'(target) * 29 - (base % Rev) + Rev) % Rev;
        return base + off;
    endfunction

    task automatic model_step();
        longint p = cyc;
        bit     busy, wc, d;
        int     a;
        if (!rst) begin
            cyc = 0; op_valid = 1'b0; done_at = -1; err_at = -1;
            return;
        end
        busy = op_valid && p > op_acc && p <= op_end;
        if (!busy && (bus.req_cpu || bus.req_io)) begin
            wc = bus.req_cpu;
            a  = wc ? int'(bus.addr_cpu) : int'(bus.addr_io);
            d  = wc && bus.dbl_cpu && DblEn;
            if (d) a = a - (a % 2);
            if (a > 107) begin
                err_at = p + 1;
            end else begin
                op_valid = 1'b1; op_cpu = wc; op_acc = p;
                op_start = first_at(p, a);
                op_end   = op_start + (d ? 58 : 29) - 1;
                done_at  = op_end + 1;
            end
        end else if (busy && p < op_start && !(op_cpu ? bus.req_cpu : bus.req_io)) begin
            op_end = p; done_at = -1;
        end
        cyc = p + 1;
    endtask

    function automatic logic [19:0] expect_vec();
        longint q = cyc;
        int     bt = int'(q % 29);
        int     wt = int'((q / 29) % 108);
        bit     g  = op_valid && q > op_acc && q <= op_end;
        bit     x  = op_valid && q >= op_start && q <= op_end;
        bit     x1 = x && (q - op_start) >= 29;
        return {5'(bt), 7'(wt), bt == 0, bt == 28, g && op_cpu, g && !op_cpu, x, x1,
                q == done_at, q == err_at};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {bus.bit_time, bus.word_time, bus.T0, bus.T28, bus.gnt_cpu, bus.gnt_io,
                bus.xfer, bus.xfer_w1, bus.done, bus.err};
    endfunction

    // Window monitor used by the directed checks.
    bit     xfer_prev = 1'b0;
    int     xs_pos = -1, xs_prev_pos = -1, xs_len = 0, xs_w1 = 0;
    longint xs_abs = 0, xs_prev_abs = 0;
    bit     xs_owner = 1'b0;
    int     done_seen = 0, err_seen = 0;

    always @(posedge CLOCK) begin
        model_step();
        if (!rst) chk_en = 1'b1;
        #1;
        if (chk_en) begin
            check_val($sformatf("cycle@%0d", cyc), 32'(dut_vec()), 32'(expect_vec()));
            if (bus.xfer && !xfer_prev) begin
                xs_prev_pos = xs_pos; xs_prev_abs = xs_abs;
                xs_pos = int'(cyc % Rev); xs_abs = cyc; xs_len = 0; xs_w1 = 0;
                xs_owner = bus.gnt_cpu;
            end
            if (bus.xfer) xs_len++;
            if (bus.xfer_w1) xs_w1++;
            if (bus.done) done_seen++;
            if (bus.err) err_seen++;
            xfer_prev = bus.xfer;
        end
    end

    task automatic wait_pos(input longint pos);
        while (cyc % Rev != pos) @(negedge CLOCK);
    endtask

    // Called at a negedge; requesters hold until their done, err, or an optional abort.
    task automatic run_txn(input bit rc, input bit ri, input int ac, input int ai, input bit dbl,
                           input int abort_after);
        bit act_c = rc, act_i = ri, pg_c = 1'b0, pg_i = 1'b0;
        int n = 0, gcnt = 0, ab = abort_after;
        bus.req_cpu = rc; bus.addr_cpu = 7'(ac); bus.dbl_cpu = dbl;
        bus.req_io = ri; bus.addr_io = 7'(ai);
        while ((act_c || act_i) && n < 8000) begin
            @(negedge CLOCK);
            n++;
            if (bus.done && pg_c) act_c = 1'b0;
            if (bus.done && pg_i) act_i = 1'b0;
            if (bus.err) begin
                if (act_c) act_c = 1'b0;
                else act_i = 1'b0;
            end
            if ((bus.gnt_cpu || bus.gnt_io) && !bus.xfer) gcnt++;
            if (ab >= 0 && gcnt > ab && !bus.xfer && (bus.gnt_cpu || bus.gnt_io)) begin
                if (bus.gnt_cpu) act_c = 1'b0;
                else act_i = 1'b0;
                ab = -1;
            end
            pg_c = bus.gnt_cpu; pg_i = bus.gnt_io;
            bus.req_cpu = act_c; bus.req_io = act_i;
        end
        check_val("txn_finished", 32'(act_c || act_i), 32'd0);
    endtask

    initial begin
        int     d0, e0;
        longint acc;
        bus.req_cpu = 1'b0; bus.addr_cpu = 7'd0; bus.dbl_cpu = 1'b0;
        bus.req_io = 1'b0; bus.addr_io = 7'd0;

        // Reset, then a full idle revolution.
        repeat (3) @(negedge CLOCK);
        check_val("rst_t0", 32'(bus.T0), 32'd1);
        check_val("rst_gnt", 32'({bus.gnt_cpu, bus.gnt_io, bus.xfer, bus.done}), 32'd0);
        rst = 1'b1;
        repeat (3140) @(negedge CLOCK);

        // CPU single word 5 accepted at word 0 bit 3.
        wait_pos(3);
        run_txn(1'b1, 1'b0, 5, 0, 1'b0, -1);
        check_val("s31_start", 32'(xs_pos), 32'd145);
        check_val("s31_len", 32'(xs_len), 32'd29);
        check_val("s31_owner", 32'(xs_owner), 32'd1);

        // Simultaneous requests: CPU first at word 10, I/O follows at word 20.
        wait_pos(40);
        run_txn(1'b1, 1'b1, 10, 20, 1'b0, -1);
        check_val("s32_cpu_pos", 32'(xs_prev_pos), 32'd290);
        check_val("s32_io_pos", 32'(xs_pos), 32'd580);
        check_val("s32_io_owner", 32'(xs_owner), 32'd0);
        check_val("s32_same_rev", 32'(xs_abs - xs_prev_abs), 32'd290);

        // Out-of-range I/O address, then direct IDLE->XFER at word 107 bit 28.
        @(negedge CLOCK);
        e0 = err_seen;
        run_txn(1'b0, 1'b1, 0, 110, 1'b0, -1);
        check_val("s33_err", 32'(err_seen - e0), 32'd1);
        wait_pos(3131);
        acc = cyc;
        run_txn(1'b1, 1'b0, 0, 0, 1'b0, -1);
        check_val("s33_direct", 32'(xs_abs - acc), 32'd1);
        check_val("s33_pos", 32'(xs_pos), 32'd0);

        // Double request at word 7.
        wait_pos(100);
        run_txn(1'b1, 1'b0, 7, 0, 1'b1, -1);
        check_val("s34_pos", 32'(xs_pos), DblEn ? 32'd174 : 32'd203);
        check_val("s34_len", 32'(xs_len), DblEn ? 32'd58 : 32'd29);
        check_val("s34_w1", 32'(xs_w1), DblEn ? 32'd29 : 32'd0);

        // Abort while waiting: no done.
        wait_pos(200);
        d0 = done_seen;
        run_txn(1'b0, 1'b1, 80, 80, 1'b0, 5);
        repeat (5) @(negedge CLOCK);
        check_val("abort_no_done", 32'(done_seen - d0), 32'd0);

        // Reset during the 13th transfer cycle abandons the window.
        bus.addr_cpu = 7'd30; bus.req_cpu = 1'b1;
        for (int i = 0; i < 8000 && !(bus.xfer && xs_len == 13); i++) @(negedge CLOCK);
        check_val("s35_reached", 32'(xs_len), 32'd13);
        d0 = done_seen;
        rst = 1'b0; bus.req_cpu = 1'b0;
        @(negedge CLOCK);
        check_val("s35_cnt", 32'({bus.bit_time, bus.word_time}), 32'd0);
        check_val("s35_idle", 32'({bus.gnt_cpu, bus.xfer, bus.done}), 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge CLOCK);
        check_val("s35_no_done", 32'(done_seen - d0), 32'd0);

        // Random traffic.
        for (int t = 0; t < 16; t++) begin
            bit rc, ri;
            rc = 1'($urandom % 2);
            ri = rc ? 1'($urandom % 2) : 1'b1;
            repeat ($urandom_range(0, 200)) @(negedge CLOCK);
            run_txn(rc, ri, $urandom_range(0, 115), $urandom_range(0, 115), 1'($urandom % 2),
                    ($urandom % 4 == 0) ? int'($urandom_range(0, 2000)) : -1);
        end
        repeat (5) @(negedge CLOCK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
